// File: rtl/psg_pkg.sv
// Shared register map, LFSR constants and width helpers for the
// psg_multichannel sound generator and its tone channels.
package psg_pkg;

  localparam logic [1:0] REG_PER_LO  = 2'd0;
  localparam logic [1:0] REG_PER_HI  = 2'd1;
  localparam logic [1:0] REG_VOL     = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam logic [1:0] GREG_NOISE  = 2'd0;
  localparam logic [1:0] GREG_MASTER = 2'd1;
  localparam logic [1:0] GREG_NDIV   = 2'd2;
  localparam logic [1:0] GREG_VIB    = 2'd3;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Galois taps 16,14,13,11 for a right-shifting register
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int chWidth(input int numCh);
    return clog2(numCh + 1);
  endfunction

  function automatic int mixWidth(input int numCh);
    return 4 + clog2(numCh + 2);
  endfunction

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/psg_multichannel_if.sv
// Strobe/address/data register write bus into psg_multichannel.
interface psg_multichannel_if #(
  parameter int ADDR_W = 4
);
  logic              write_strobe;
  logic [ADDR_W-1:0] address;
  logic [7:0]        data;

  modport master (output write_strobe, address, data);
  modport slave  (input  write_strobe, address, data);
endinterface

// File: rtl/psg_tone_ch.sv
// One square-wave tone channel: shadowed period register, volume/enable
// and the half-period counter that toggles the wave.
module psg_tone_ch #(
  parameter int PERIOD_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                weLo,
  input  logic                weHi,
  input  logic                weVol,
  input  logic [7:0]          data,
  input  logic [PERIOD_W-1:0] perOffset,
  output logic                wave,
  output logic [3:0]          vol,
  output logic                en
);

  logic [7:0]          perShadow;
  logic [PERIOD_W-1:0] perLive;
  logic [PERIOD_W-1:0] perEff;
  logic [PERIOD_W-1:0] cnt;

  assign perEff = perLive + perOffset;

  // The low byte waits in the shadow so the high write commits both halves at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perShadow <= '0;
      perLive   <= '0;
      vol       <= '0;
      en        <= 1'b0;
    end else begin
      if (weLo)  perShadow <= data;
      if (weHi)  perLive   <= {data[PERIOD_W-9:0], perShadow};
      if (weVol) begin
        vol <= data[3:0];
        en  <= data[7];
      end
    end
  end

  // >= rather than == so a period lowered under the count wraps immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!en || perEff == '0) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (cnt >= perEff - PERIOD_W'(1)) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/psg_multichannel.sv
// Multichannel PSG: NUM_CH tone channels + LFSR noise, mixed and PWM-rendered.
// Optional triangle vibrato on channel 0 when PSG_VIBRATO_EN is defined.
module psg_multichannel
  import psg_pkg::*;
#(
  parameter  int NUM_CH      = 3,
  parameter  int PERIOD_W    = 12,
  parameter  int PWM_W       = 8,
  parameter  int NOISE_DIV_W = 8,
  localparam int CH_W        = chWidth(NUM_CH),
  localparam int ADDR_W      = CH_W + 2,
  localparam int MIX_W       = mixWidth(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  psg_multichannel_if.slave  bus,
  output logic               signal_out,
  output logic [MIX_W-1:0]   mix_level,
  output logic [NUM_CH-1:0]  wave_o,
  output logic               noise_o
);

  logic [CH_W-1:0]        bank;
  logic [1:0]             regSel;
  logic                   globalWe;

  logic [3:0]             chVol [NUM_CH];
  logic [NUM_CH-1:0]      chEn;
  logic [PERIOD_W-1:0]    vibOffset;

  logic [3:0]             nVol;
  logic                   nEn;
  logic                   masterEn;
  logic [NOISE_DIV_W-1:0] nDiv;
  logic [NOISE_DIV_W-1:0] divCnt;
  logic [15:0]            lfsr;

  logic [MIX_W-1:0]       mixSum;
  logic [MIX_W-1:0]       mixLevel_p1;
  logic [PWM_W-1:0]       pwmCnt;
  logic [PWM_W-1:0]       duty_p2;
  logic                   sig_p2;

  assign bank     = bus.address[ADDR_W-1:2];
  assign regSel   = bus.address[1:0];
  assign globalWe = bus.write_strobe && (bank == CH_W'(NUM_CH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic chWe;
    assign chWe = bus.write_strobe && (bank == CH_W'(c));

    psg_tone_ch #(.PERIOD_W(PERIOD_W)) uCh (
      .clk       (clk),
      .rst       (rst),
      .weLo      (chWe && regSel == REG_PER_LO),
      .weHi      (chWe && regSel == REG_PER_HI),
      .weVol     (chWe && regSel == REG_VOL),
      .data      (bus.data),
      .perOffset ((c == 0) ? vibOffset : {PERIOD_W{1'b0}}),
      .wave      (wave_o[c]),
      .vol       (chVol[c]),
      .en        (chEn[c])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nVol     <= '0;
      nEn      <= 1'b0;
      masterEn <= 1'b0;
      nDiv     <= '0;
    end else if (globalWe) begin
      case (regSel)
        GREG_NOISE: begin
          nVol <= bus.data[3:0];
          nEn  <= bus.data[7];
        end
        GREG_MASTER: masterEn <= bus.data[0];
        GREG_NDIV:   nDiv     <= NOISE_DIV_W'(bus.data);
        default: ;
      endcase
    end
  end

`ifdef PSG_VIBRATO_EN
  logic [3:0]  vibDepth;
  logic [3:0]  vibSpeed;
  logic [18:0] lfoDiv;
  logic [18:0] lfoLimit;
  logic [3:0]  lfo;
  logic        lfoUp;

  // speed 15 shifts to 2^19, which wraps to zero so the limit becomes all-ones
  assign lfoLimit  = (19'd1 << (5'(vibSpeed) + 5'd4)) - 19'd1;
  assign vibOffset = {{(PERIOD_W-4){1'b0}}, lfo};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vibDepth <= '0;
      vibSpeed <= '0;
    end else if (globalWe && regSel == GREG_VIB) begin
      vibDepth <= bus.data[3:0];
      vibSpeed <= bus.data[7:4];
    end
  end

  // Triangle: climb to depth, turn around, descend to zero, turn around
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfoDiv <= '0;
      lfo    <= '0;
      lfoUp  <= 1'b1;
    end else if (lfoDiv == lfoLimit) begin
      lfoDiv <= '0;
      if (lfoUp) begin
        if (lfo < vibDepth) begin
          lfo <= lfo + 4'd1;
        end else begin
          lfoUp <= 1'b0;
          if (lfo != 4'd0) lfo <= lfo - 4'd1;
        end
      end else begin
        if (lfo != 4'd0) begin
          lfo <= lfo - 4'd1;
        end else begin
          lfoUp <= 1'b1;
          if (vibDepth != 4'd0) lfo <= lfo + 4'd1;
        end
      end
    end else begin
      lfoDiv <= lfoDiv + 19'd1;
    end
  end
`else
  assign vibOffset = '0;
`endif

  // Noise: divider gates one LFSR step per (nDiv+1) cycles; disabled freezes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCnt <= '0;
      lfsr   <= LFSR_SEED;
    end else if (!nEn) begin
      divCnt <= '0;
    end else if (divCnt == nDiv) begin
      divCnt <= '0;
      lfsr   <= lfsrStep(lfsr);
    end else begin
      divCnt <= divCnt + NOISE_DIV_W'(1);
    end
  end

  always_comb begin
    mixSum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wave_o[c] && chEn[c]) mixSum = mixSum + MIX_W'(chVol[c]);
    end
    if (lfsr[0] && nEn) mixSum = mixSum + MIX_W'(nVol);
  end

  // Stage p1: registered mixer sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mixLevel_p1 <= '0;
    else      mixLevel_p1 <= masterEn ? mixSum : '0;
  end

  // Stage p2: duty only reloads at the period boundary, so no mid-period glitch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwmCnt  <= '0;
      duty_p2 <= '0;
      sig_p2  <= 1'b0;
    end else begin
      pwmCnt <= pwmCnt + PWM_W'(1);
      if (&pwmCnt) duty_p2 <= PWM_W'(mixLevel_p1) << (PWM_W - MIX_W);
      sig_p2 <= (pwmCnt < duty_p2);
    end
  end

  assign mix_level  = mixLevel_p1;
  assign signal_out = sig_p2;
  assign noise_o    = lfsr[0];

endmodule

// File: tb/tb_psg_multichannel.sv
// Scoreboard bench for psg_multichannel: a cycle reference model pushes the
// expected outputs every clock, feature tasks pop and compare them.
module tb_psg_multichannel;

  localparam int NUM_CH   = 3;
  localparam int PERIOD_W = 12;
  localparam int PWM_W    = 8;
  localparam int NDIV_W   = 8;
  localparam int MIX_W    = 7;
  localparam int ADDR_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signal_out;
  logic noise_o;
  logic [MIX_W-1:0]  mix_level;
  logic [NUM_CH-1:0] wave_o;

  psg_multichannel_if #(.ADDR_W(ADDR_W)) bus();

  psg_multichannel #(
    .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .PWM_W(PWM_W), .NOISE_DIV_W(NDIV_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .signal_out(signal_out), .mix_level(mix_level), .wave_o(wave_o), .noise_o(noise_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             sig;
    logic [MIX_W-1:0] mix;
    logic [2:0]       wave;
    logic             noise;
  } exp_t;

  exp_t sb[$];
  exp_t expc;
  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [7:0]  mShadow [NUM_CH];
  logic [11:0] mPer    [NUM_CH];
  logic [3:0]  mVol    [NUM_CH];
  logic        mEn     [NUM_CH];
  logic [11:0] mCnt    [NUM_CH];
  logic [2:0]  mWave;
  logic [3:0]  mNVol;
  logic        mNEn, mMaster, mSig, mLfoUp;
  logic [7:0]  mNDiv, mDivC, mPwm, mDuty;
  logic [15:0] mLfsr;
  logic [6:0]  mMix;
  int          mLfo, mLfoDiv, mDepth, mSpeed;

  always @(posedge clk or negedge rst) begin : model
    logic [11:0] pe;
    int sum, b, r;
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mShadow[i] = 0; mPer[i] = 0; mVol[i] = 0; mEn[i] = 0; mCnt[i] = 0;
      end
      mWave = 0; mNVol = 0; mNEn = 0; mMaster = 0; mNDiv = 0; mDivC = 0;
      mLfsr = 16'hACE1; mMix = 0; mPwm = 0; mDuty = 0; mSig = 0;
      mLfo = 0; mLfoDiv = 0; mLfoUp = 1; mDepth = 0; mSpeed = 0;
    end else begin
      mSig = (mPwm < mDuty);
      if (mPwm == 8'hFF) mDuty = {mMix, 1'b0};
      mPwm = mPwm + 8'd1;
      sum = 0;
      for (int i = 0; i < NUM_CH; i++) if (mWave[i] && mEn[i]) sum += int'(mVol[i]);
      if (mLfsr[0] && mNEn) sum += int'(mNVol);
      mMix = mMaster ? 7'(sum) : 7'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        pe = mPer[i] + ((i == 0) ? 12'(mLfo) : 12'd0);
        if (!mEn[i] || pe == 0) begin
          mCnt[i] = 0; mWave[i] = 1'b0;
        end else if (int'(mCnt[i]) + 1 >= int'(pe)) begin
          mCnt[i] = 0; mWave[i] = ~mWave[i];
        end else begin
          mCnt[i] = mCnt[i] + 12'd1;
        end
      end
      if (!mNEn) mDivC = 0;
      else if (mDivC == mNDiv) begin
        mDivC = 0;
        mLfsr = mLfsr[0] ? ((mLfsr >> 1) ^ 16'hB400) : (mLfsr >> 1);
      end else mDivC = mDivC + 8'd1;
`ifdef PSG_VIBRATO_EN
      if (mLfoDiv == (1 << (mSpeed + 4)) - 1) begin
        mLfoDiv = 0;
        if (mLfoUp) begin
          if (mLfo < mDepth) mLfo++;
          else begin mLfoUp = 0; if (mLfo > 0) mLfo--; end
        end else begin
          if (mLfo > 0) mLfo--;
          else begin mLfoUp = 1; if (mDepth > 0) mLfo++; end
        end
      end else mLfoDiv++;
`endif
      if (bus.write_strobe) begin
        b = int'(bus.address[3:2]);
        r = int'(bus.address[1:0]);
        if (b < NUM_CH) begin
          if (r == 0) mShadow[b] = bus.data;
          if (r == 1) mPer[b] = {bus.data[3:0], mShadow[b]};
          if (r == 2) begin mVol[b] = bus.data[3:0]; mEn[b] = bus.data[7]; end
        end else begin
          if (r == 0) begin mNVol = bus.data[3:0]; mNEn = bus.data[7]; end
          if (r == 1) mMaster = bus.data[0];
          if (r == 2) mNDiv = bus.data;
`ifdef PSG_VIBRATO_EN
          if (r == 3) begin mDepth = int'(bus.data[3:0]); mSpeed = int'(bus.data[7:4]); end
`endif
        end
      end
    end
    if (clk) begin
      e.sig = mSig; e.mix = mMix; e.wave = mWave; e.noise = mLfsr[0];
      sb.push_back(e);
    end
  end

  task automatic step();
    @(negedge clk);
    if (sb.size() == 0) begin
      nChecks++;
      $display("FAIL scoreboard_empty: got 0 entries, required 1");
    end else begin
      expc = sb.pop_front();
    end
  endtask

  task automatic wr(input logic [1:0] bank, input logic [1:0] rg, input logic [7:0] val);
    bus.write_strobe = 1'b1;
    bus.address      = {bank, rg};
    bus.data         = val;
    step();
    bus.write_strobe = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    step();
    step();
    nChecks++; if (signal_out !== 1'b0) $display("FAIL reset_sig: got %b required 0", signal_out); else nPass++;
    nChecks++; if (mix_level !== 7'd0) $display("FAIL reset_mix: got %0d required 0", mix_level); else nPass++;
    nChecks++; if (wave_o !== 3'b000) $display("FAIL reset_wave: got %b required 000", wave_o); else nPass++;
    nChecks++; if (noise_o !== 1'b1) $display("FAIL reset_noise: got %b required 1", noise_o); else nPass++;
    rst = 1'b1;
  endtask

  task automatic test_tone();
    int lastT = -1;
    logic prevW = 1'b0;
    wr(2'd0, 2'd0, 8'h04);
    wr(2'd0, 2'd1, 8'h00);
    wr(2'd3, 2'd1, 8'h01);
    wr(2'd0, 2'd2, 8'h8F);
    for (int i = 0; i < 40; i++) begin
      step();
      nChecks++; if (wave_o !== expc.wave) $display("FAIL tone_wave: cycle %0d got %b required %b", i, wave_o, expc.wave); else nPass++;
      nChecks++; if (mix_level !== expc.mix) $display("FAIL tone_mix: cycle %0d got %0d required %0d", i, mix_level, expc.mix); else nPass++;
      if (wave_o[0] !== prevW) begin
        if (lastT >= 0) begin
          nChecks++; if (i - lastT != 4) $display("FAIL tone_spacing: got %0d required 4", i - lastT); else nPass++;
        end
        lastT = i;
        prevW = wave_o[0];
      end
    end
  endtask

  task automatic test_shadow();
    int lastT = -1;
    int nInt = 0;
    logic prevW;
    wr(2'd0, 2'd0, 8'h10);
    prevW = wave_o[0];
    for (int i = 0; i < 24; i++) begin
      step();
      nChecks++; if (wave_o !== expc.wave) $display("FAIL shadow_hold_wave: cycle %0d got %b required %b", i, wave_o, expc.wave); else nPass++;
      if (wave_o[0] !== prevW) begin
        if (lastT >= 0) begin
          nChecks++; if (i - lastT != 4) $display("FAIL shadow_hold_spacing: got %0d required 4", i - lastT); else nPass++;
        end
        lastT = i;
        prevW = wave_o[0];
      end
    end
    wr(2'd0, 2'd1, 8'h01);
    lastT = -1;
    prevW = wave_o[0];
    for (int i = 0; i < 600; i++) begin
      step();
      nChecks++; if (wave_o !== expc.wave) $display("FAIL shadow_commit_wave: cycle %0d got %b required %b", i, wave_o, expc.wave); else nPass++;
      if (wave_o[0] !== prevW) begin
        if (lastT >= 0) begin
          nInt++;
          nChecks++; if (i - lastT != 272) $display("FAIL shadow_commit_spacing: got %0d required 272", i - lastT); else nPass++;
        end
        lastT = i;
        prevW = wave_o[0];
      end
    end
    nChecks++; if (nInt < 1) $display("FAIL shadow_intervals: got %0d required >=1", nInt); else nPass++;
  endtask

  task automatic test_mix_all();
    logic saw60 = 1'b0;
    doReset();
    wr(2'd3, 2'd2, 8'hFF);
    for (int c = 0; c < NUM_CH; c++) begin
      wr(2'(c), 2'd0, 8'h40);
      wr(2'(c), 2'd1, 8'h00);
    end
    wr(2'd3, 2'd1, 8'h01);
    for (int c = 0; c < NUM_CH; c++) wr(2'(c), 2'd2, 8'h8F);
    wr(2'd3, 2'd0, 8'h8F);
    for (int i = 0; i < 200; i++) begin
      step();
      nChecks++; if (mix_level !== expc.mix) $display("FAIL mixall_mix: cycle %0d got %0d required %0d", i, mix_level, expc.mix); else nPass++;
      nChecks++; if (wave_o !== expc.wave) $display("FAIL mixall_wave: cycle %0d got %b required %b", i, wave_o, expc.wave); else nPass++;
      nChecks++; if (noise_o !== expc.noise) $display("FAIL mixall_noise: cycle %0d got %b required %b", i, noise_o, expc.noise); else nPass++;
      if (mix_level === 7'd60) saw60 = 1'b1;
    end
    nChecks++; if (saw60 !== 1'b1) $display("FAIL mixall_peak60: got seen=%b required 1", saw60); else nPass++;
  endtask

  task automatic test_pwm();
    int highsIdle = 0;
    int highsOn = 0;
    doReset();
    wr(2'd0, 2'd0, 8'hFF);
    wr(2'd0, 2'd1, 8'h0F);
    wr(2'd0, 2'd2, 8'h8F);
    wr(2'd3, 2'd1, 8'h01);
    for (int i = 0; i < 4700; i++) begin
      step();
      nChecks++; if (signal_out !== expc.sig) $display("FAIL pwm_sig: cycle %0d got %b required %b", i, signal_out, expc.sig); else nPass++;
      nChecks++; if (mix_level !== expc.mix) $display("FAIL pwm_mix: cycle %0d got %0d required %0d", i, mix_level, expc.mix); else nPass++;
      if (i >= 100 && i < 356 && signal_out === 1'b1) highsIdle++;
      if (i >= 4400 && i < 4656 && signal_out === 1'b1) highsOn++;
    end
    nChecks++; if (highsIdle != 0) $display("FAIL pwm_zero_duty: got %0d high cycles required 0", highsIdle); else nPass++;
    nChecks++; if (highsOn != 30) $display("FAIL pwm_duty15: got %0d high cycles required 30", highsOn); else nPass++;
  endtask

  task automatic test_noise();
    int changes = 0;
    logic prevN;
    logic frozen;
    doReset();
    wr(2'd3, 2'd2, 8'h00);
    wr(2'd3, 2'd0, 8'h8F);
    wr(2'd3, 2'd1, 8'h01);
    prevN = noise_o;
    for (int i = 0; i < 64; i++) begin
      step();
      nChecks++; if (noise_o !== expc.noise) $display("FAIL noise_div0: cycle %0d got %b required %b", i, noise_o, expc.noise); else nPass++;
      nChecks++; if (mix_level !== expc.mix) $display("FAIL noise_mix: cycle %0d got %0d required %0d", i, mix_level, expc.mix); else nPass++;
      if (noise_o !== prevN) changes++;
      prevN = noise_o;
    end
    nChecks++; if (changes == 0) $display("FAIL noise_activity: got %0d bit changes required >0", changes); else nPass++;
    wr(2'd3, 2'd2, 8'h03);
    for (int i = 0; i < 64; i++) begin
      step();
      nChecks++; if (noise_o !== expc.noise) $display("FAIL noise_div3: cycle %0d got %b required %b", i, noise_o, expc.noise); else nPass++;
    end
    wr(2'd3, 2'd0, 8'h0F);
    frozen = expc.noise;
    for (int i = 0; i < 40; i++) begin
      step();
      nChecks++; if (noise_o !== frozen) $display("FAIL noise_frozen: cycle %0d got %b required %b", i, noise_o, frozen); else nPass++;
      nChecks++; if (mix_level !== expc.mix) $display("FAIL noise_off_mix: cycle %0d got %0d required %0d", i, mix_level, expc.mix); else nPass++;
    end
  endtask

  task automatic test_vibrato();
    int lastT = -1;
    logic prevW = 1'b0;
    doReset();
    wr(2'd0, 2'd0, 8'h64);
    wr(2'd0, 2'd1, 8'h00);
    wr(2'd0, 2'd2, 8'h8F);
    wr(2'd3, 2'd1, 8'h01);
    wr(2'd3, 2'd3, 8'h02);
    for (int i = 0; i < 500; i++) begin
      step();
      nChecks++; if (wave_o !== expc.wave) $display("FAIL vib_wave: cycle %0d got %b required %b", i, wave_o, expc.wave); else nPass++;
      nChecks++; if (mix_level !== expc.mix) $display("FAIL vib_mix: cycle %0d got %0d required %0d", i, mix_level, expc.mix); else nPass++;
`ifndef PSG_VIBRATO_EN
      if (wave_o[0] !== prevW) begin
        if (lastT >= 0) begin
          nChecks++; if (i - lastT != 100) $display("FAIL vib_plain_period: got %0d required 100", i - lastT); else nPass++;
        end
        lastT = i;
        prevW = wave_o[0];
      end
`endif
    end
    wr(2'd0, 2'd3, 8'hFF);
    for (int i = 0; i < 250; i++) begin
      step();
      nChecks++; if (wave_o !== expc.wave) $display("FAIL reserved_wave: cycle %0d got %b required %b", i, wave_o, expc.wave); else nPass++;
    end
  endtask

  task automatic test_reset_midrun();
    doReset();
    wr(2'd0, 2'd0, 8'h04);
    wr(2'd0, 2'd1, 8'h00);
    wr(2'd0, 2'd2, 8'h8F);
    wr(2'd3, 2'd1, 8'h01);
    for (int i = 0; i < 12; i++) begin
      step();
      nChecks++; if (mix_level !== expc.mix) $display("FAIL midrun_pre_mix: cycle %0d got %0d required %0d", i, mix_level, expc.mix); else nPass++;
    end
    #2 rst = 1'b0;
    #1;
    nChecks++; if (signal_out !== 1'b0) $display("FAIL midrun_async_sig: got %b required 0", signal_out); else nPass++;
    nChecks++; if (mix_level !== 7'd0) $display("FAIL midrun_async_mix: got %0d required 0", mix_level); else nPass++;
    nChecks++; if (wave_o !== 3'b000) $display("FAIL midrun_async_wave: got %b required 000", wave_o); else nPass++;
    nChecks++; if (noise_o !== 1'b1) $display("FAIL midrun_async_noise: got %b required 1", noise_o); else nPass++;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      nChecks++; if (wave_o !== expc.wave) $display("FAIL midrun_post_wave: cycle %0d got %b required %b", i, wave_o, expc.wave); else nPass++;
      nChecks++; if (mix_level !== expc.mix) $display("FAIL midrun_post_mix: cycle %0d got %0d required %0d", i, mix_level, expc.mix); else nPass++;
    end
  endtask

  initial begin
    bus.write_strobe = 1'b0;
    bus.address      = '0;
    bus.data         = '0;
    test_reset();
    test_tone();
    test_shadow();
    test_mix_all();
    test_pwm();
    test_noise();
    test_vibrato();
    test_reset_midrun();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion (%0d/%0d so far)", nPass, nChecks);
    $fatal(1, "watchdog");
  end

endmodule
